// File: rtl/tile_read_arbiter_if.sv
// Tile read arbiter bundle: requester side, BRAM read-port side and status.
// Requests are level-held until the matching grant pulse.
// The arbiter never stalls its output stream; consumers must accept every oValid beat.
`timescale 1ns/1ps
interface tile_read_arbiter_if #(
  parameter int ADDR_W = 19
);
  logic              iFrameReady;
  logic              iReq0;
  logic              iReq1;
  logic [5:0]        iTileX0;
  logic [5:0]        iTileX1;
  logic [4:0]        iTileY0;
  logic [4:0]        iTileY1;
  logic              oGnt0;
  logic              oGnt1;
  logic              oEn;
  logic [ADDR_W-1:0] oAddr;
  logic              oValid;
  logic              oOwner;
  logic              oFirst;
  logic              oLast;
  logic              oErr;
  logic              oBusy;

  // Requester / test side
  modport master (
    output iFrameReady, iReq0, iReq1, iTileX0, iTileX1, iTileY0, iTileY1,
    input  oGnt0, oGnt1, oEn, oAddr, oValid, oOwner, oFirst, oLast, oErr, oBusy
  );

  // Arbiter side
  modport slave (
    input  iFrameReady, iReq0, iReq1, iTileX0, iTileX1, iTileY0, iTileY1,
    output oGnt0, oGnt1, oEn, oAddr, oValid, oOwner, oFirst, oLast, oErr, oBusy
  );
endinterface

// File: rtl/tile_read_arbiter.sv
// Round-robin arbiter that streams one 16x16 tile per grant out of a frame BRAM.
// Latency: grant -> first oEn 1 cycle, oEn -> oValid RD_LAT cycles; one idle cycle between bursts.
// Backpressure: none on the data side; requesters simply wait (level-held) until granted.
`timescale 1ns/1ps
module tile_read_arbiter #(
  parameter int IMG_WIDTH   = 640,
  parameter int TILE_WIDTH  = 16,
  parameter int TILE_HEIGHT = 16,
  parameter int NUM_TILES_X = 40,
  parameter int NUM_TILES_Y = 30,
  parameter int ADDR_W      = 19,
  parameter int RD_LAT      = 2
) (
  input logic                iClk,
  input logic                iRst,
  tile_read_arbiter_if.slave bus
);

  localparam int COL_W = $clog2(TILE_WIDTH);
  localparam int ROW_W = $clog2(TILE_HEIGHT);

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t            state;
  logic              prio;       // requester favoured on the next contested grant
  logic              owner_q;    // requester that owns the current burst
  logic [5:0]        tx_q;
  logic [4:0]        ty_q;
  logic [ROW_W-1:0]  row_q;
  logic [COL_W-1:0]  col_q;
  logic              en_q;
  logic [ADDR_W-1:0] addr_q;
  logic              gnt0_q;
  logic              gnt1_q;
  logic              err_q;
  logic              fst_q;
  logic              lst_q;
  logic [RD_LAT-1:0] vld_p;
  logic [RD_LAT-1:0] own_p;
  logic [RD_LAT-1:0] fst_p;
  logic [RD_LAT-1:0] lst_p;

  logic              req0_m;
  logic              req1_m;
  logic              any_req;
  logic              pick;
  logic [5:0]        pick_x;
  logic [4:0]        pick_y;
  logic              pick_bad;
  logic              row_last;
  logic              col_last;
  logic [ADDR_W-1:0] addr_full;

  // Arbitration: a requester whose grant pulse is showing this cycle is masked,
  // so a requester that drops its level on seeing the grant is never served twice.
  always_comb begin
    req0_m   = bus.iReq0 & ~gnt0_q;
    req1_m   = bus.iReq1 & ~gnt1_q;
    any_req  = req0_m | req1_m;
    pick     = (req0_m & req1_m) ? prio : req1_m;
    pick_x   = pick ? bus.iTileX1 : bus.iTileX0;
    pick_y   = pick ? bus.iTileY1 : bus.iTileY0;
    pick_bad = (32'(pick_x) >= 32'(NUM_TILES_X)) || (32'(pick_y) >= 32'(NUM_TILES_Y));
  end

  assign row_last = (row_q == ROW_W'(TILE_HEIGHT - 1));
  assign col_last = (col_q == COL_W'(TILE_WIDTH - 1));

  // Full-width address arithmetic, truncated to the BRAM address width
  assign addr_full = ADDR_W'(((32'(ty_q) * 32'(TILE_HEIGHT) + 32'(row_q)) * 32'(IMG_WIDTH))
                             + 32'(tx_q) * 32'(TILE_WIDTH) + 32'(col_q));

  // Control FSM: grant in IDLE, walk the tile in raster order in ISSUE
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state   <= IDLE;
      prio    <= 1'b0;
      owner_q <= 1'b0;
      tx_q    <= '0;
      ty_q    <= '0;
      row_q   <= '0;
      col_q   <= '0;
      en_q    <= 1'b0;
      addr_q  <= '0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      err_q   <= 1'b0;
      fst_q   <= 1'b0;
      lst_q   <= 1'b0;
    end else begin
      gnt0_q <= 1'b0;
      gnt1_q <= 1'b0;
      err_q  <= 1'b0;
      en_q   <= 1'b0;
      fst_q  <= 1'b0;
      lst_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.iFrameReady && any_req) begin
            gnt0_q  <= ~pick;
            gnt1_q  <= pick;
            prio    <= ~pick;
            owner_q <= pick;
            tx_q    <= pick_x;
            ty_q    <= pick_y;
            row_q   <= '0;
            col_q   <= '0;
            if (pick_bad) begin
              err_q <= 1'b1;
            end else begin
              state <= ISSUE;
            end
          end
        end
        ISSUE: begin
          en_q   <= 1'b1;
          addr_q <= addr_full;
          fst_q  <= (row_q == '0) && (col_q == '0);
          lst_q  <= row_last && col_last;
          if (col_last) begin
            col_q <= '0;
            row_q <= row_q + 1'b1;
            if (row_last) begin
              state <= IDLE;
            end
          end else begin
            col_q <= col_q + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Read-latency shadow pipeline, free-running alongside the BRAM
  always_ff @(posedge iClk) begin
    if (iRst) begin
      vld_p <= '0;
      own_p <= '0;
      fst_p <= '0;
      lst_p <= '0;
    end else begin
      vld_p[0] <= en_q;
      own_p[0] <= owner_q;
      fst_p[0] <= fst_q;
      lst_p[0] <= lst_q;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_p[i] <= vld_p[i-1];
        own_p[i] <= own_p[i-1];
        fst_p[i] <= fst_p[i-1];
        lst_p[i] <= lst_p[i-1];
      end
    end
  end

  assign bus.oGnt0  = gnt0_q;
  assign bus.oGnt1  = gnt1_q;
  assign bus.oErr   = err_q;
  assign bus.oEn    = en_q;
  assign bus.oAddr  = addr_q;
  assign bus.oValid = vld_p[RD_LAT-1];
  assign bus.oOwner = own_p[RD_LAT-1];
  assign bus.oFirst = fst_p[RD_LAT-1];
  assign bus.oLast  = lst_p[RD_LAT-1];
  assign bus.oBusy  = (state == ISSUE) | en_q | (|vld_p);

endmodule

// File: tb/tb_tile_read_arbiter.sv
// Directed bench for tile_read_arbiter: reset, single bursts, round-robin, errors,
// frame gating and mid-burst reset. Outputs are sampled on the falling edge.
`timescale 1ns/1ps
module tb_tile_read_arbiter;
  localparam int RD_LAT = 2;
  localparam int ADDR_W = 19;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_pass = 0;

  tile_read_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

  tile_read_arbiter #(.RD_LAT(RD_LAT), .ADDR_W(ADDR_W)) dut (
    .iClk (clk),
    .iRst (rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic idle_inputs();
    bus.iFrameReady = 1'b1;
    bus.iReq0 = 1'b0;  bus.iReq1 = 1'b0;
    bus.iTileX0 = '0;  bus.iTileY0 = '0;
    bus.iTileX1 = '0;  bus.iTileY1 = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_gnt(output logic g0, output logic g1, output logic er, output int lat);
    lat = -1; g0 = 1'b0; g1 = 1'b0; er = 1'b0;
    for (int i = 1; i <= 50; i++) begin
      @(negedge clk);
      if (bus.oGnt0 || bus.oGnt1) begin
        g0 = bus.oGnt0; g1 = bus.oGnt1; er = bus.oErr; lat = i;
        break;
      end
    end
  endtask

  task automatic wait_idle(output int left);
    left = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!bus.oBusy) begin
        left = 1;
        break;
      end
    end
  endtask

  // Request one tile from one requester and follow the whole burst
  task automatic test_burst(input string nm, input bit who, input int tx, input int ty,
                            input int exp_first, input int exp_last, input bit drop_fr);
    logic g0, g1, er;
    int lat, en_bad, addr_bad, vld_bad, flag_bad, busy_bad, misc_bad, first_a, last_a;
    en_bad = 0; addr_bad = 0; vld_bad = 0; flag_bad = 0; busy_bad = 0; misc_bad = 0;
    first_a = -1; last_a = -1;
    if (who == 1'b0) begin
      bus.iReq0 = 1'b1; bus.iTileX0 = 6'(tx); bus.iTileY0 = 5'(ty);
    end else begin
      bus.iReq1 = 1'b1; bus.iTileX1 = 6'(tx); bus.iTileY1 = 5'(ty);
    end
    wait_gnt(g0, g1, er, lat);
    bus.iReq0 = 1'b0; bus.iReq1 = 1'b0;
    n_chk++;
    if (lat !== 1) $display("FAIL %s grant latency: got %0d cycles, expected 1", nm, lat);
    else n_pass++;
    n_chk++;
    if ({g1, g0} !== (who ? 2'b10 : 2'b01)) $display("FAIL %s grant select: got {g1,g0}=%b, expected %b", nm, {g1, g0}, (who ? 2'b10 : 2'b01));
    else n_pass++;
    n_chk++;
    if (er !== 1'b0) $display("FAIL %s error on grant: got %b, expected 0", nm, er);
    else n_pass++;
    for (int k = 1; k <= 256 + RD_LAT + 1; k++) begin
      int idx, v, ea;
      logic ev;
      @(negedge clk);
      if (drop_fr && k == 10) bus.iFrameReady = 1'b0;
      idx = (k <= 256) ? k - 1 : 255;
      ea  = (ty * 16 + idx / 16) * 640 + tx * 16 + idx % 16;
      if (bus.oEn !== (k <= 256)) en_bad++;
      if (bus.oAddr !== ADDR_W'(ea)) addr_bad++;
      if (k == 1) first_a = int'(bus.oAddr);
      if (k == 256) last_a = int'(bus.oAddr);
      v  = k - RD_LAT;
      ev = (v >= 1) && (v <= 256);
      if (bus.oValid !== ev) vld_bad++;
      if (bus.oFirst !== (ev && v == 1) || bus.oLast !== (ev && v == 256)) flag_bad++;
      if (ev && bus.oOwner !== who) flag_bad++;
      if (bus.oBusy !== (k <= 256 + RD_LAT)) busy_bad++;
      if (bus.oGnt0 || bus.oGnt1 || bus.oErr) misc_bad++;
    end
    bus.iFrameReady = 1'b1;
    n_chk++;
    if (en_bad !== 0) $display("FAIL %s oEn window: got %0d bad cycles, expected 0", nm, en_bad);
    else n_pass++;
    n_chk++;
    if (addr_bad !== 0) $display("FAIL %s address sequence: got %0d bad cycles, expected 0", nm, addr_bad);
    else n_pass++;
    n_chk++;
    if (first_a !== exp_first) $display("FAIL %s first address: got %0d, expected %0d", nm, first_a, exp_first);
    else n_pass++;
    n_chk++;
    if (last_a !== exp_last) $display("FAIL %s last address: got %0d, expected %0d", nm, last_a, exp_last);
    else n_pass++;
    n_chk++;
    if (vld_bad !== 0) $display("FAIL %s oValid timing: got %0d bad cycles, expected 0", nm, vld_bad);
    else n_pass++;
    n_chk++;
    if (flag_bad !== 0) $display("FAIL %s first/last/owner: got %0d bad cycles, expected 0", nm, flag_bad);
    else n_pass++;
    n_chk++;
    if (busy_bad !== 0) $display("FAIL %s oBusy: got %0d bad cycles, expected 0", nm, busy_bad);
    else n_pass++;
    n_chk++;
    if (misc_bad !== 0) $display("FAIL %s stray grant/err: got %0d cycles, expected 0", nm, misc_bad);
    else n_pass++;
  endtask

  task automatic test_reset();
    idle_inputs();
    bus.iReq0 = 1'b1; bus.iReq1 = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_chk++;
    if ({bus.oEn, bus.oGnt0, bus.oGnt1, bus.oErr, bus.oBusy, bus.oValid, bus.oFirst, bus.oLast} !== 8'h00)
      $display("FAIL reset outputs: got %b, expected 00000000",
               {bus.oEn, bus.oGnt0, bus.oGnt1, bus.oErr, bus.oBusy, bus.oValid, bus.oFirst, bus.oLast});
    else n_pass++;
    n_chk++;
    if (bus.oAddr !== '0) $display("FAIL reset oAddr: got %0d, expected 0", bus.oAddr);
    else n_pass++;
    idle_inputs();
    rst = 1'b0;
  endtask

  task automatic test_single_tile();
    do_reset();
    test_burst("tile00", 1'b0, 0, 0, 0, 9615, 1'b0);
  endtask

  task automatic test_last_tile();
    do_reset();
    // Frame-ready drops mid-burst; the burst must still complete
    test_burst("tile39_29", 1'b0, 39, 29, 297584, 307199, 1'b1);
  endtask

  task automatic test_back_to_back();
    int gseq[$];
    int oseq[$];
    int zeros, ngaps, gap_bad;
    bit seen_en;
    logic [3:0] gp, op;
    zeros = 0; ngaps = 0; gap_bad = 0; seen_en = 1'b0;
    idle_inputs();
    rst = 1'b1;
    bus.iReq0 = 1'b1; bus.iTileX0 = 6'd1; bus.iTileY0 = 5'd0;
    bus.iReq1 = 1'b1; bus.iTileX1 = 6'd2; bus.iTileY1 = 5'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 1400; i++) begin
      @(negedge clk);
      if (bus.oGnt0) gseq.push_back(0);
      if (bus.oGnt1) gseq.push_back(1);
      if (gseq.size() >= 4) begin
        bus.iReq0 = 1'b0; bus.iReq1 = 1'b0;
      end
      if (bus.oValid && bus.oFirst) oseq.push_back(int'(bus.oOwner));
      if (bus.oEn) begin
        if (seen_en && zeros > 0) begin
          ngaps++;
          if (zeros != 1) gap_bad++;
        end
        seen_en = 1'b1;
        zeros = 0;
      end else if (seen_en) begin
        zeros++;
      end
      if (gseq.size() >= 4 && !bus.oBusy) break;
    end
    gp = '0; op = '0;
    for (int i = 0; i < 4; i++) begin
      if (i < gseq.size()) gp[i] = gseq[i][0];
      if (i < oseq.size()) op[i] = oseq[i][0];
    end
    n_chk++;
    if (gseq.size() !== 4) $display("FAIL rr grant count: got %0d, expected 4", gseq.size());
    else n_pass++;
    n_chk++;
    if (gp !== 4'b1010) $display("FAIL rr grant order: got %b (bit0 first), expected 1010", gp);
    else n_pass++;
    n_chk++;
    if (oseq.size() !== 4 || op !== 4'b1010) $display("FAIL rr owner order: got %b from %0d bursts, expected 1010 from 4", op, oseq.size());
    else n_pass++;
    n_chk++;
    if (ngaps !== 3) $display("FAIL rr gap count: got %0d, expected 3", ngaps);
    else n_pass++;
    n_chk++;
    if (gap_bad !== 0) $display("FAIL rr gap length: got %0d gaps not 1 cycle, expected 0", gap_bad);
    else n_pass++;
  endtask

  task automatic test_err();
    logic g0, g1, er;
    int lat, quiet_bad, ok;
    do_reset();
    bus.iReq1 = 1'b1; bus.iTileX1 = 6'd40; bus.iTileY1 = 5'd0;
    wait_gnt(g0, g1, er, lat);
    bus.iReq1 = 1'b0;
    n_chk++;
    if ({g1, g0, er} !== 3'b101) $display("FAIL err x40 grant: got {g1,g0,err}=%b, expected 101", {g1, g0, er});
    else n_pass++;
    quiet_bad = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.oEn || bus.oErr || bus.oBusy || bus.oGnt1) quiet_bad++;
    end
    n_chk++;
    if (quiet_bad !== 0) $display("FAIL err no reads: got %0d active cycles, expected 0", quiet_bad);
    else n_pass++;
    // Both request: pointer moved past 1, so requester 0 wins
    bus.iReq0 = 1'b1; bus.iTileX0 = 6'd1; bus.iTileY0 = 5'd1;
    bus.iReq1 = 1'b1; bus.iTileX1 = 6'd2; bus.iTileY1 = 5'd2;
    wait_gnt(g0, g1, er, lat);
    bus.iReq0 = 1'b0; bus.iReq1 = 1'b0;
    n_chk++;
    if ({g1, g0, er} !== 3'b010) $display("FAIL err then both #1: got {g1,g0,err}=%b, expected 010", {g1, g0, er});
    else n_pass++;
    wait_idle(ok);
    n_chk++;
    if (ok !== 1) $display("FAIL err burst drain: got busy after 400 cycles, expected idle");
    else n_pass++;
    // Pointer now favours 1; an error grant to 1 must hand priority back to 0
    bus.iReq1 = 1'b1; bus.iTileX1 = 6'd40; bus.iTileY1 = 5'd0;
    wait_gnt(g0, g1, er, lat);
    bus.iReq1 = 1'b0;
    n_chk++;
    if ({g1, g0, er} !== 3'b101) $display("FAIL err x40 second: got {g1,g0,err}=%b, expected 101", {g1, g0, er});
    else n_pass++;
    bus.iReq0 = 1'b1; bus.iReq1 = 1'b1;
    wait_gnt(g0, g1, er, lat);
    bus.iReq0 = 1'b0; bus.iReq1 = 1'b0;
    n_chk++;
    if ({g1, g0, er} !== 3'b010) $display("FAIL err then both #2: got {g1,g0,err}=%b, expected 010", {g1, g0, er});
    else n_pass++;
    wait_idle(ok);
    bus.iReq0 = 1'b1; bus.iTileX0 = 6'd5; bus.iTileY0 = 5'd30;
    wait_gnt(g0, g1, er, lat);
    bus.iReq0 = 1'b0;
    n_chk++;
    if ({g1, g0, er} !== 3'b011) $display("FAIL err y30 grant: got {g1,g0,err}=%b, expected 011", {g1, g0, er});
    else n_pass++;
    @(negedge clk);
    n_chk++;
    if ({bus.oErr, bus.oEn} !== 2'b00) $display("FAIL err pulse width: got {err,en}=%b, expected 00", {bus.oErr, bus.oEn});
    else n_pass++;
  endtask

  task automatic test_frame_ready();
    int gcnt, ok;
    do_reset();
    bus.iFrameReady = 1'b0;
    bus.iReq0 = 1'b1; bus.iTileX0 = 6'd0; bus.iTileY0 = 5'd0;
    gcnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.oGnt0 || bus.oGnt1 || bus.oEn) gcnt++;
    end
    n_chk++;
    if (gcnt !== 0) $display("FAIL frame gate: got %0d grant/en cycles, expected 0", gcnt);
    else n_pass++;
    bus.iFrameReady = 1'b1;
    @(negedge clk);
    n_chk++;
    if (bus.oGnt0 !== 1'b1) $display("FAIL frame release grant: got %b, expected 1", bus.oGnt0);
    else n_pass++;
    bus.iReq0 = 1'b0;
    wait_idle(ok);
    n_chk++;
    if (ok !== 1) $display("FAIL frame burst drain: got busy after 400 cycles, expected idle");
    else n_pass++;
  endtask

  task automatic test_reset_mid_burst();
    logic g0, g1, er;
    int lat, vbad;
    do_reset();
    bus.iReq0 = 1'b1; bus.iTileX0 = 6'd3; bus.iTileY0 = 5'd2;
    wait_gnt(g0, g1, er, lat);
    bus.iReq0 = 1'b0;
    repeat (101) @(negedge clk);
    n_chk++;
    if (bus.oAddr !== ADDR_W'(24372)) $display("FAIL midrst pixel100 addr: got %0d, expected 24372", bus.oAddr);
    else n_pass++;
    rst = 1'b1;
    @(negedge clk);
    n_chk++;
    if ({bus.oEn, bus.oBusy, bus.oValid} !== 3'b000) $display("FAIL midrst outputs: got {en,busy,valid}=%b, expected 000", {bus.oEn, bus.oBusy, bus.oValid});
    else n_pass++;
    n_chk++;
    if (bus.oAddr !== '0) $display("FAIL midrst oAddr: got %0d, expected 0", bus.oAddr);
    else n_pass++;
    rst = 1'b0;
    vbad = 0;
    for (int i = 0; i < RD_LAT + 3; i++) begin
      @(negedge clk);
      if (bus.oValid || bus.oEn) vbad++;
    end
    n_chk++;
    if (vbad !== 0) $display("FAIL midrst stale valid: got %0d cycles, expected 0", vbad);
    else n_pass++;
    test_burst("after_rst", 1'b1, 2, 1, 10272, 19887, 1'b0);
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single_tile();
    test_last_tile();
    test_back_to_back();
    test_err();
    test_frame_ready();
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/tile_read_arbiter.md
TILE_READ_ARBITER -- requirements
Module: tile_read_arbiter

Interface
REQ-001 Parameters SHALL be: IMG_WIDTH 640 (pixels per line); TILE_WIDTH 16 and TILE_HEIGHT 16 (tile size); NUM_TILES_X 40 and NUM_TILES_Y 30 (tile grid); ADDR_W 19 (BRAM address width); RD_LAT 2 (BRAM read latency in cycles, 1..4).
REQ-002 Ports SHALL be:
- iClk  in  1  single clock.
- iRst  in  1  synchronous, active-high reset.
- iFrameReady  in  1  frame fully written to BRAM; reads permitted.
- iReq0 / iReq1  in  1  tile read request, requester 0 / 1.
- iTileX0 / iTileX1  in  6  requested tile column.
- iTileY0 / iTileY1  in  5  requested tile row.
- oGnt0 / oGnt1  out  1  one-cycle request acceptance.
- oEn  out  1  BRAM read-port enable (enb/regceb).
- oAddr  out  ADDR_W  BRAM read address.
- oValid  out  1  BRAM data valid this cycle.
- oOwner  out  1  requester owning oValid data.
- oFirst / oLast  out  1  first / last pixel of tile, aligned with oValid.
- oErr  out  1  one-cycle pulse: out-of-range tile rejected.
- oBusy  out  1  burst in progress.

Function
REQ-003 The FSM SHALL have two states, IDLE and ISSUE.
REQ-004 In IDLE with iFrameReady=1 and at least one iReq high, the block SHALL grant exactly one requester that cycle: pulse its oGnt, latch its tile X/Y, and enter ISSUE next cycle.
REQ-005 Arbitration SHALL be round-robin: with both requests high, the requester not served last wins; after reset, requester 0 has priority.
REQ-006 With iFrameReady=0, the block SHALL issue no grants; requests stay pending.
REQ-007 Requests SHALL be level-held by the requester until its oGnt; tile X/Y SHALL be sampled only in the grant cycle.
REQ-008 A granted tile with X>=NUM_TILES_X or Y>=NUM_TILES_Y SHALL pulse oErr in the grant cycle, issue no reads, remain in IDLE, and still advance the round-robin pointer.
REQ-009 ISSUE SHALL assert oEn for exactly TILE_WIDTH*TILE_HEIGHT (256) consecutive cycles, one address per cycle, in raster order within the tile (column fastest).
REQ-010 The address SHALL be (ty*TILE_HEIGHT+row)*IMG_WIDTH + tx*TILE_WIDTH + col, computed at full width and truncated to ADDR_W; no overflow occurs for in-range tiles.
REQ-011 After the 256th address the FSM SHALL return to IDLE; arbitration SHALL occur in that IDLE cycle, giving a one-cycle oEn gap between back-to-back bursts.
REQ-012 oValid, oOwner, oFirst and oLast SHALL equal oEn, the owner, (row=0,col=0) and (row=15,col=15) delayed by exactly RD_LAT cycles through a shift pipeline that runs independently of the FSM.
REQ-013 oBusy SHALL be high in ISSUE and while any oValid is still pending in the pipeline.
REQ-014 oEn, oGnt0/1 and oErr SHALL be low whenever not explicitly asserted; oAddr SHALL hold its last value when oEn=0.
REQ-015 A request deasserted before its grant SHALL be ignored; a requester re-requesting during its own burst SHALL wait for the next IDLE cycle.
REQ-016 iFrameReady falling during ISSUE SHALL NOT abort the burst.

Reset
REQ-017 With iRst=1 at a clock edge, the following SHALL all be 0 on the next cycle: state IDLE, oEn, oAddr, oGnt0/1, oErr, oBusy, the whole valid/owner/first/last pipeline, and the round-robin pointer (requester 0 favoured).
REQ-018 Reset asserted mid-burst SHALL abort the burst immediately; no oValid SHALL appear afterwards from pre-reset reads.

Verification
REQ-019 iFrameReady=1, iReq0 with tile (0,0) -> oGnt0 for 1 cycle; oAddr sequence 0..15, 640..655, ..., last address 9615; oValid from grant+1+RD_LAT for 256 cycles; oFirst on address 0 data; oLast on address 9615 data.
REQ-020 Tile (39,29) -> first address 297584, last address 307199, no oErr.
REQ-021 iReq0 and iReq1 both held high from reset -> grants in order 0,1,0,1; oOwner matches each burst; 1-cycle oEn gap between bursts.
REQ-022 iReq1 with tile (40,0) -> oGnt1 and oErr pulse in the same cycle, no oEn, and the next simultaneous request is granted to requester 0.
REQ-023 iFrameReady=0 with iReq0 high for 10 cycles -> no grant; iFrameReady raised -> oGnt0 the next cycle.
REQ-024 iRst pulsed at burst pixel 100 -> oEn and oBusy low the next cycle; oValid stays low for at least RD_LAT cycles; a new request is served normally afterwards.
